// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for the alarm clock: per-frame snapshot, leading-zero
// blanking, colon on S0 parity and whole-display flashing while the alarm is active.
module clock_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int BLANK_LZ     = 1,
  parameter int ACT_LOW      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [2:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [2:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       alarm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int   PW  = $clog2(SCAN_DIV);
  localparam int   FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic INV = (ACT_LOW != 0);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx, idx_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          phase, phase_n;
  logic [1:0]    s_h1, n_h1;
  logic [3:0]    s_h0, n_h0, s_m0, n_m0, s_s0, n_s0;
  logic [2:0]    s_m1, n_m1, s_s1, n_s1;
  logic          s_alarm, n_alarm;
  logic          tick, wrap, dark, dp_hi;
  logic [3:0]    digit;
  logic [5:0]    an_hi;
  logic [6:0]    seg_hi;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0111111;
      4'd1:    dec7 = 7'b0000110;
      4'd2:    dec7 = 7'b1011011;
      4'd3:    dec7 = 7'b1001111;
      4'd4:    dec7 = 7'b1100110;
      4'd5:    dec7 = 7'b1101101;
      4'd6:    dec7 = 7'b1111101;
      4'd7:    dec7 = 7'b0000111;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1101111;
      default: dec7 = 7'b1000000;
    endcase
  endfunction

  // Everything the outputs need on a tick edge is computed from next-state values, so the
  // slot shown on the wrapping edge already uses the freshly loaded snapshot and phase.
  always_comb begin
    tick  = (prescaler == PW'(SCAN_DIV - 1));
    wrap  = tick && (idx == 3'd5);
    idx_n = idx;
    if (tick) idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

    n_h1 = s_h1; n_h0 = s_h0; n_m1 = s_m1; n_m0 = s_m0;
    n_s1 = s_s1; n_s0 = s_s0; n_alarm = s_alarm;
    if (wrap) begin
      n_h1 = H_in1; n_h0 = H_in0; n_m1 = M_in1; n_m0 = M_in0;
      n_s1 = S_in1; n_s0 = S_in0; n_alarm = alarm;
    end

    frame_cnt_n = frame_cnt;
    phase_n     = phase;
    if (wrap) begin
      if (!alarm) begin
        frame_cnt_n = '0;
        phase_n     = 1'b0;
      end else if (s_alarm) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt_n = '0;
          phase_n     = ~phase;
        end else begin
          frame_cnt_n = frame_cnt + 1'b1;
        end
      end
    end

    case (idx_n)
      3'd0:    digit = n_s0;
      3'd1:    digit = {1'b0, n_s1};
      3'd2:    digit = n_m0;
      3'd3:    digit = {1'b0, n_m1};
      3'd4:    digit = n_h0;
      default: digit = {2'b00, n_h1};
    endcase
    seg_hi = dec7(digit);
    an_hi  = 6'b000001 << idx_n;
    dp_hi  = ((idx_n == 3'd2) || (idx_n == 3'd4)) && !n_s0[0];
    dark   = ((idx_n == 3'd5) && (BLANK_LZ != 0) && (n_h1 == 2'd0)) || (n_alarm && phase_n);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      idx       <= 3'd5;
      frame_cnt <= '0;
      phase     <= 1'b0;
      s_h1 <= '0; s_h0 <= '0; s_m1 <= '0; s_m0 <= '0;
      s_s1 <= '0; s_s0 <= '0; s_alarm <= 1'b0;
      an  <= {6{INV}};
      seg <= {7{INV}};
      dp  <= INV;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      idx       <= idx_n;
      frame_cnt <= frame_cnt_n;
      phase     <= phase_n;
      s_h1 <= n_h1; s_h0 <= n_h0; s_m1 <= n_m1; s_m0 <= n_m0;
      s_s1 <= n_s1; s_s0 <= n_s0; s_alarm <= n_alarm;
      if (!en || (tick && dark)) begin
        an  <= {6{INV}};
        seg <= {7{INV}};
        dp  <= INV;
      end else if (tick) begin
        an  <= an_hi ^ {6{INV}};
        seg <= seg_hi ^ {7{INV}};
        dp  <= dp_hi ^ INV;
      end
    end
  end
endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: slot/frame-level reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_clock_display_scan;
  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0;
  logic [2:0] M_in1 = '0;
  logic [3:0] M_in0 = '0;
  logic [2:0] S_in1 = '0;
  logic [3:0] S_in0 = '0;
  logic       alarm = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // reference model state: frame snapshot, consecutive alarm frames, expected outputs
  logic [6:0] dec_tab[16];
  logic [3:0] snap_d[6];
  logic       snap_alarm = 1'b0;
  int         alarm_run = 0;
  logic [5:0] exp_an = 6'h3f;
  logic [6:0] exp_seg = 7'h7f;
  logic       exp_dp = 1'b1;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .BLANK_LZ(1), .ACT_LOW(1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .S_in1(S_in1), .S_in0(S_in0), .alarm(alarm),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b want=%b", name, edge_n, got, want);
    end
  endtask

  task automatic set_bcd(input logic [1:0] h1, input logic [3:0] h0, input logic [2:0] m1,
                         input logic [3:0] m0, input logic [2:0] s1, input logic [3:0] s0);
    H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
  endtask

  // returns at the falling edge following rising edge n (counted from reset release)
  task automatic goto_edge(input int n);
    int budget;
    budget = 4000;
    do begin
      @(negedge clk);
      budget--;
    end while (edge_n < n && budget > 0);
    if (edge_n != n) begin
      checks++;
      errors++;
      $display("FAIL goto_edge reached=%0d want=%0d", edge_n, n);
    end
  endtask

  // Slot k (0-based) is shown from rising edge SD*(k+1); each group of six slots is one frame.
  always @(posedge clk) begin
    int  slot;
    bit  tick_m;
    bit  dark_m;
    if (!reset) begin
      edge_n = 0;
      alarm_run = 0;
      snap_alarm = 1'b0;
      for (int i = 0; i < 6; i++) snap_d[i] = 4'd0;
      exp_an = 6'h3f; exp_seg = 7'h7f; exp_dp = 1'b1;
    end else begin
      edge_n++;
      tick_m = ((edge_n % SD) == 0);
      slot = 0;
      if (tick_m) begin
        slot = ((edge_n / SD) - 1) % 6;
        if (slot == 0) begin
          snap_d[0] = S_in0;
          snap_d[1] = {1'b0, S_in1};
          snap_d[2] = M_in0;
          snap_d[3] = {1'b0, M_in1};
          snap_d[4] = H_in0;
          snap_d[5] = {2'b00, H_in1};
          snap_alarm = alarm;
          alarm_run = alarm ? alarm_run + 1 : 0;
        end
      end
      if (!en) begin
        exp_an = 6'h3f; exp_seg = 7'h7f; exp_dp = 1'b1;
      end else if (tick_m) begin
        dark_m = (snap_alarm && ((((alarm_run - 1) / BF) % 2) == 1)) ||
                 (slot == 5 && snap_d[5] == 4'd0);
        if (dark_m) begin
          exp_an = 6'h3f; exp_seg = 7'h7f; exp_dp = 1'b1;
        end else begin
          exp_an  = ~(6'b000001 << slot);
          exp_seg = ~dec_tab[snap_d[slot]];
          exp_dp  = ~((slot == 2 || slot == 4) && !snap_d[0][0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("scan_an", {1'b0, an}, {1'b0, exp_an});
    chk("scan_seg", seg, exp_seg);
    chk("scan_dp", {6'b0, dp}, {6'b0, exp_dp});
  end

  initial begin
    dec_tab[0] = 7'b0111111; dec_tab[1] = 7'b0000110; dec_tab[2] = 7'b1011011;
    dec_tab[3] = 7'b1001111; dec_tab[4] = 7'b1100110; dec_tab[5] = 7'b1101101;
    dec_tab[6] = 7'b1111101; dec_tab[7] = 7'b0000111; dec_tab[8] = 7'b1111111;
    dec_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1000000;

    // reset release with 12:34:56
    set_bcd(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
    repeat (2) @(negedge clk);
    chk("reset_an", {1'b0, an}, 7'h3f);
    chk("reset_seg", seg, 7'h7f);
    reset = 1'b1;
    goto_edge(1);  chk("e1_an", {1'b0, an}, 7'h3f);
    goto_edge(3);  chk("e3_an", {1'b0, an}, 7'h3f);
    goto_edge(4);  chk("e4_an", {1'b0, an}, 7'b0111110);
                   chk("e4_seg", seg, 7'b0000010);
                   chk("e4_dp", {6'b0, dp}, 7'd1);
    goto_edge(8);  chk("e8_an", {1'b0, an}, 7'b0111101);
                   chk("e8_seg", seg, 7'b0010010);
    // inputs change mid-frame; the current frame must stay coherent
    goto_edge(9);  set_bcd(2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9);
    goto_edge(12); chk("e12_an", {1'b0, an}, 7'b0111011);
                   chk("e12_seg", seg, 7'b0011001);
                   chk("e12_dp", {6'b0, dp}, 7'd0);
    goto_edge(16); chk("e16_seg", seg, 7'b0110000);
    goto_edge(20); chk("e20_seg", seg, 7'b0100100);
    goto_edge(24); chk("e24_an", {1'b0, an}, 7'b0011111);
                   chk("e24_seg", seg, 7'b1111001);
    goto_edge(28); chk("e28_an", {1'b0, an}, 7'b0111110);
                   chk("e28_seg", seg, 7'b0010000);
    goto_edge(36); chk("e36_seg", seg, 7'b0010000);
                   chk("e36_dp", {6'b0, dp}, 7'd1);

    // 05:00:00: leading zero blanked
    set_bcd(2'd0, 4'd5, 3'd0, 4'd0, 3'd0, 4'd0);
    goto_edge(68); chk("lz_h0_an", {1'b0, an}, 7'b0101111);
                   chk("lz_h0_seg", seg, 7'b0010010);
    goto_edge(72); chk("lz_h1_an", {1'b0, an}, 7'h3f);
                   chk("lz_h1_seg", seg, 7'h7f);
                   chk("lz_h1_dp", {6'b0, dp}, 7'd1);

    // out-of-range digit shows a dash
    set_bcd(2'd1, 4'd2, 3'd3, 4'hC, 3'd5, 4'd6);
    goto_edge(84); chk("dash_seg", seg, 7'b0111111);

    // alarm flashing: two frames lit, two dark
    set_bcd(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
    alarm = 1'b1;
    goto_edge(100); chk("alm_f1_an", {1'b0, an}, 7'b0111110);
    goto_edge(124); chk("alm_f2_an", {1'b0, an}, 7'b0111110);
    goto_edge(148); chk("alm_f3_an", {1'b0, an}, 7'h3f);
                    chk("alm_f3_seg", seg, 7'h7f);
    goto_edge(176); chk("alm_f4_an", {1'b0, an}, 7'h3f);
    goto_edge(196); chk("alm_f5_an", {1'b0, an}, 7'b0111110);
    goto_edge(225); alarm = 1'b0;
    goto_edge(244); chk("alm_off_an", {1'b0, an}, 7'b0111110);
    alarm = 1'b1;
    goto_edge(268); chk("alm_re_f1_an", {1'b0, an}, 7'b0111110);
    goto_edge(316); chk("alm_re_f3_an", {1'b0, an}, 7'h3f);
    alarm = 1'b0;
    goto_edge(340); chk("alm_drop_an", {1'b0, an}, 7'b0111110);
                    chk("alm_drop_seg", seg, 7'b0000010);

    // en pulse
    goto_edge(341); en = 1'b0;
    goto_edge(342); chk("en0_an", {1'b0, an}, 7'h3f);
    en = 1'b1;
    goto_edge(343); chk("en1_hold_an", {1'b0, an}, 7'h3f);
    goto_edge(344); chk("en1_tick_an", {1'b0, an}, 7'b0111101);

    // reset mid slot 3
    goto_edge(353); reset = 1'b0;
    #1 chk("rst_mid_an", {1'b0, an}, 7'h3f);
    chk("rst_mid_seg", seg, 7'h7f);
    @(negedge clk); reset = 1'b1;
    goto_edge(3);  chk("rst_e3_an", {1'b0, an}, 7'h3f);
    goto_edge(4);  chk("rst_e4_an", {1'b0, an}, 7'b0111110);

    // a few more frames under the model, including en low across several ticks
    set_bcd(2'd0, 4'd9, 3'd4, 4'd7, 3'd0, 4'd1); repeat (24) @(negedge clk);
    set_bcd(2'd2, 4'd0, 3'd0, 4'd8, 3'd3, 4'd2); en = 1'b0; repeat (20) @(negedge clk);
    en = 1'b1;
    set_bcd(2'd1, 4'hF, 3'd7, 4'hA, 3'd6, 4'd3); repeat (30) @(negedge clk);
    set_bcd(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0); alarm = 1'b1; repeat (120) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
